// File: rtl/nested_ifs_pkg.sv
// Shared types and constants for the nested-ifs atom driver.
// Config word layout, select-word structs and FSM encoding.
package nested_ifs_pkg;

    typedef logic [31:0] int32_t;
    typedef logic [1:0]  int2_t;
    typedef logic        bool;

    localparam int CFG_WORDS = 13;

    localparam logic [3:0] ADDR_CONS_1  = 4'd0;
    localparam logic [3:0] ADDR_CONS_3  = 4'd2;
    localparam logic [3:0] ADDR_CONS_5  = 4'd4;
    localparam logic [3:0] ADDR_CONS_8  = 4'd7;
    localparam logic [3:0] ADDR_CONS_10 = 4'd9;
    localparam logic [3:0] ADDR_CONS_11 = 4'd10;
    localparam logic [3:0] ADDR_SEL1    = 4'd11;
    localparam logic [3:0] ADDR_SEL2    = 4'd12;

    // Select word 1: one-bit selects, sel_1 at bit 0
    typedef struct packed {
        logic [18:0] rsvd;
        bool sel_19;
        bool sel_16;
        bool sel_15;
        bool sel_14;
        bool sel_13;
        bool sel_10;
        bool sel_7;
        bool sel_6;
        bool sel_5;
        bool sel_4;
        bool sel_3;
        bool sel_2;
        bool sel_1;
    } sel1_t;

    // Select word 2: two-bit selects from bit 0, then relational ops
    typedef struct packed {
        logic [9:0] rsvd;
        int2_t rel_op3;
        int2_t rel_op2;
        int2_t rel_op1;
        int2_t sel_21;
        int2_t sel_20;
        int2_t sel_18;
        int2_t sel_17;
        int2_t sel_12;
        int2_t sel_11;
        int2_t sel_9;
        int2_t sel_8;
    } sel2_t;

    typedef logic [CFG_WORDS-1:0][31:0] cfg_bank_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } fsm_t;

    // Leaf state-muxes pick the constant, leaf mux3 selects pick cons
    localparam int32_t INIT_SEL1 = 32'h0000_18C0;
    localparam int32_t INIT_SEL2 = 32'h0000_AAAA;

    function automatic int32_t cfg_mask(
        input logic [3:0] addr,
        input int32_t     data
    );
        int32_t m;
        m = data;
        if (addr == ADDR_SEL1) m = data & 32'h0000_1FFF;
        if (addr == ADDR_SEL2) m = data & 32'h003F_FFFF;
        return m;
    endfunction

endpackage

// File: rtl/nested_ifs_driver_res_fifo.sv
// Synchronous result FIFO for the nested-ifs driver.
// DEPTH must be a power of two so the pointers wrap naturally.
module nested_ifs_res_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full     = (cnt == FULL_CNT);
    assign empty    = (cnt == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/nested_ifs_driver.sv
// Initiator-side driver for the nested-ifs counter atom.
// Optional STATE_SEED_EN adds seed_value to seed the atom in INIT.
module nested_ifs_driver
    import nested_ifs_pkg::*;
#(
    parameter int RES_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef STATE_SEED_EN
    input  logic [31:0] seed_value,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pkt_1,
    input  logic [31:0] in_pkt_2,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [31:0] cfg_data,
    input  logic        cfg_commit,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_read,
    output logic [31:0] res_write,
    output logic [31:0] a_pkt_1,
    output logic [31:0] a_pkt_2,
    output logic [31:0] a_cons_1,
    output logic [31:0] a_cons_2,
    output logic [31:0] a_cons_3,
    output logic [31:0] a_cons_4,
    output logic [31:0] a_cons_5,
    output logic [31:0] a_cons_6,
    output logic [31:0] a_cons_7,
    output logic [31:0] a_cons_8,
    output logic [31:0] a_cons_9,
    output logic [31:0] a_cons_10,
    output logic [31:0] a_cons_11,
    output logic        a_sel_1,
    output logic        a_sel_2,
    output logic        a_sel_3,
    output logic        a_sel_4,
    output logic        a_sel_5,
    output logic        a_sel_6,
    output logic        a_sel_7,
    output logic [1:0]  a_sel_8,
    output logic [1:0]  a_sel_9,
    output logic        a_sel_10,
    output logic [1:0]  a_sel_11,
    output logic [1:0]  a_sel_12,
    output logic        a_sel_13,
    output logic        a_sel_14,
    output logic        a_sel_15,
    output logic        a_sel_16,
    output logic [1:0]  a_sel_17,
    output logic [1:0]  a_sel_18,
    output logic        a_sel_19,
    output logic [1:0]  a_sel_20,
    output logic [1:0]  a_sel_21,
    output logic [1:0]  a_rel_op1,
    output logic [1:0]  a_rel_op2,
    output logic [1:0]  a_rel_op3,
    input  logic [31:0] a_o_read,
    input  logic [31:0] a_o_write
);

    fsm_t      state_q;
    fsm_t      state_d;
    cfg_bank_t shadow_q;
    cfg_bank_t shadow_d;
    cfg_bank_t active_q;
    cfg_bank_t drv;
    int32_t    drv_pkt_1;
    int32_t    drv_pkt_2;
    int32_t    seed;
    sel1_t     s1;
    sel2_t     s2;
    bool       init_q;
    bool       fire;
    bool       fifo_full;
    bool       fifo_empty;
    logic [63:0] fifo_out;
    logic      unused_bits;

`ifdef STATE_SEED_EN
    assign seed = seed_value;
`else
    assign seed = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_INIT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_INIT: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    assign init_q   = (state_q == ST_INIT);
    assign in_ready = (state_q == ST_RUN) && !fifo_full;
    assign fire     = in_valid && in_ready;

    // Commit copies the shadow bank including a same-cycle write
    always_comb begin
        shadow_d = shadow_q;
        if (cfg_we && (cfg_addr <= ADDR_SEL2))
            shadow_d[cfg_addr] = cfg_mask(cfg_addr, cfg_data);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            if (cfg_commit) active_q <= shadow_d;
        end
    end

    // Idle cycles drive all-zero, which makes the atom hold its state
    always_comb begin
        drv       = '0;
        drv_pkt_1 = '0;
        drv_pkt_2 = '0;
        unique case (1'b1)
            init_q: begin
                drv[ADDR_SEL1]    = INIT_SEL1;
                drv[ADDR_SEL2]    = INIT_SEL2;
                drv[ADDR_CONS_3]  = seed;
                drv[ADDR_CONS_5]  = seed;
                drv[ADDR_CONS_8]  = seed;
                drv[ADDR_CONS_10] = seed;
            end
            fire: begin
                drv       = active_q;
                drv_pkt_1 = in_pkt_1;
                drv_pkt_2 = in_pkt_2;
            end
            default: ;
        endcase
    end

    assign s1 = sel1_t'(drv[ADDR_SEL1]);
    assign s2 = sel2_t'(drv[ADDR_SEL2]);
    assign unused_bits = ^{s1.rsvd, s2.rsvd};

    assign a_pkt_1   = drv_pkt_1;
    assign a_pkt_2   = drv_pkt_2;
    assign a_cons_1  = drv[ADDR_CONS_1];
    assign a_cons_2  = drv[1];
    assign a_cons_3  = drv[ADDR_CONS_3];
    assign a_cons_4  = drv[3];
    assign a_cons_5  = drv[ADDR_CONS_5];
    assign a_cons_6  = drv[5];
    assign a_cons_7  = drv[6];
    assign a_cons_8  = drv[ADDR_CONS_8];
    assign a_cons_9  = drv[8];
    assign a_cons_10 = drv[ADDR_CONS_10];
    assign a_cons_11 = drv[ADDR_CONS_11];

    assign a_sel_1  = s1.sel_1;
    assign a_sel_2  = s1.sel_2;
    assign a_sel_3  = s1.sel_3;
    assign a_sel_4  = s1.sel_4;
    assign a_sel_5  = s1.sel_5;
    assign a_sel_6  = s1.sel_6;
    assign a_sel_7  = s1.sel_7;
    assign a_sel_10 = s1.sel_10;
    assign a_sel_13 = s1.sel_13;
    assign a_sel_14 = s1.sel_14;
    assign a_sel_15 = s1.sel_15;
    assign a_sel_16 = s1.sel_16;
    assign a_sel_19 = s1.sel_19;

    assign a_sel_8   = s2.sel_8;
    assign a_sel_9   = s2.sel_9;
    assign a_sel_11  = s2.sel_11;
    assign a_sel_12  = s2.sel_12;
    assign a_sel_17  = s2.sel_17;
    assign a_sel_18  = s2.sel_18;
    assign a_sel_20  = s2.sel_20;
    assign a_sel_21  = s2.sel_21;
    assign a_rel_op1 = s2.rel_op1;
    assign a_rel_op2 = s2.rel_op2;
    assign a_rel_op3 = s2.rel_op3;

    nested_ifs_res_fifo #(
        .DEPTH (RES_DEPTH),
        .WIDTH (64)
    ) u_res_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fire),
        .push_data ({a_o_read, a_o_write}),
        .pop       (res_valid && res_ready),
        .pop_data  (fifo_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign res_valid = !fifo_empty;
    assign res_read  = res_valid ? fifo_out[63:32] : '0;
    assign res_write = res_valid ? fifo_out[31:0]  : '0;

endmodule

// File: tb/tb_nested_ifs_driver.sv
// Scoreboard bench for nested_ifs_driver with a reduced atom stand-in:
// two-level nested ifs over rel_op compares, four leaves A + B - C.
module tb_nested_ifs_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef STATE_SEED_EN
    localparam logic [31:0] S = 32'h10;
    logic [31:0] seed_value = S;
`else
    localparam logic [31:0] S = 32'h0;
`endif

    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pkt_1 = '0;
    logic [31:0] in_pkt_2 = '0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [31:0] cfg_data = '0;
    logic        cfg_commit = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_read, res_write;
    logic [31:0] a_pkt_1, a_pkt_2;
    logic [31:0] a_cons_1, a_cons_2, a_cons_3, a_cons_4, a_cons_5, a_cons_6;
    logic [31:0] a_cons_7, a_cons_8, a_cons_9, a_cons_10, a_cons_11;
    logic        a_sel_1, a_sel_2, a_sel_3, a_sel_4, a_sel_5, a_sel_6, a_sel_7;
    logic        a_sel_10, a_sel_13, a_sel_14, a_sel_15, a_sel_16, a_sel_19;
    logic [1:0]  a_sel_8, a_sel_9, a_sel_11, a_sel_12;
    logic [1:0]  a_sel_17, a_sel_18, a_sel_20, a_sel_21;
    logic [1:0]  a_rel_op1, a_rel_op2, a_rel_op3;
    logic [31:0] a_o_read, a_o_write;

    nested_ifs_driver #(.RES_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef STATE_SEED_EN
        .seed_value(seed_value),
`endif
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pkt_1(in_pkt_1), .in_pkt_2(in_pkt_2),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_read(res_read), .res_write(res_write),
        .a_pkt_1(a_pkt_1), .a_pkt_2(a_pkt_2),
        .a_cons_1(a_cons_1), .a_cons_2(a_cons_2), .a_cons_3(a_cons_3),
        .a_cons_4(a_cons_4), .a_cons_5(a_cons_5), .a_cons_6(a_cons_6),
        .a_cons_7(a_cons_7), .a_cons_8(a_cons_8), .a_cons_9(a_cons_9),
        .a_cons_10(a_cons_10), .a_cons_11(a_cons_11),
        .a_sel_1(a_sel_1), .a_sel_2(a_sel_2), .a_sel_3(a_sel_3),
        .a_sel_4(a_sel_4), .a_sel_5(a_sel_5), .a_sel_6(a_sel_6),
        .a_sel_7(a_sel_7), .a_sel_8(a_sel_8), .a_sel_9(a_sel_9),
        .a_sel_10(a_sel_10), .a_sel_11(a_sel_11), .a_sel_12(a_sel_12),
        .a_sel_13(a_sel_13), .a_sel_14(a_sel_14), .a_sel_15(a_sel_15),
        .a_sel_16(a_sel_16), .a_sel_17(a_sel_17), .a_sel_18(a_sel_18),
        .a_sel_19(a_sel_19), .a_sel_20(a_sel_20), .a_sel_21(a_sel_21),
        .a_rel_op1(a_rel_op1), .a_rel_op2(a_rel_op2), .a_rel_op3(a_rel_op3),
        .a_o_read(a_o_read), .a_o_write(a_o_write)
    );

    logic tb_unused;
    assign tb_unused = ^{a_sel_3, a_sel_4, a_sel_5, a_sel_6, a_sel_14, a_sel_15};

    // Atom stand-in: state updates every clock to o__write
    logic [31:0] atom_state;
    always @(posedge clk) atom_state <= a_o_write;

    function automatic logic cmp(input logic [1:0] op, input logic [31:0] a, b);
        case (op)
            2'd0:    return a == b;
            2'd1:    return a != b;
            2'd2:    return a < b;
            default: return a >= b;
        endcase
    endfunction

    function automatic logic [31:0] mux3(input logic [1:0] s,
                                         input logic [31:0] p1, p2, c);
        case (s)
            2'd0:    return p1;
            2'd1:    return p2;
            2'd2:    return c;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] leaf(input logic st, input logic [1:0] ma, mb,
                                         input logic [31:0] hi, lo, stv, p1, p2);
        return (st ? hi : stv) + mux3(ma, p1, p2, lo) - mux3(mb, p1, p2, lo);
    endfunction

    logic c1, c2, c3;
    logic [31:0] l1, l2, l3, l4;
    always_comb begin
        c1 = cmp(a_rel_op1, a_sel_1 ? atom_state : a_pkt_1, a_cons_1);
        c2 = cmp(a_rel_op2, a_sel_2 ? atom_state : a_pkt_1, a_cons_2);
        c3 = cmp(a_rel_op3, a_sel_13 ? atom_state : a_pkt_1, a_cons_7);
        l1 = leaf(a_sel_7, a_sel_8, a_sel_9, a_cons_3, a_cons_4, atom_state, a_pkt_1, a_pkt_2);
        l2 = leaf(a_sel_10, a_sel_11, a_sel_12, a_cons_5, a_cons_6, atom_state, a_pkt_1, a_pkt_2);
        l3 = leaf(a_sel_16, a_sel_17, a_sel_18, a_cons_8, a_cons_9, atom_state, a_pkt_1, a_pkt_2);
        l4 = leaf(a_sel_19, a_sel_20, a_sel_21, a_cons_10, a_cons_11, atom_state, a_pkt_1, a_pkt_2);
        a_o_write = c1 ? (c2 ? l1 : l2) : (c3 ? l3 : l4);
        a_o_read  = atom_state;
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare each consumed result against the scoreboard
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got %h %h expected none",
                         res_read, res_write);
            end else begin
                check("result", {res_read, res_write}, exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [31:0] d, input logic c);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        cfg_commit = c;
        tick(1);
        cfg_we = 1'b0;
        cfg_commit = 1'b0;
    endtask

    task automatic send(input logic [31:0] p1, p2, input logic [63:0] exp);
        in_pkt_1 = p1;
        in_pkt_2 = p2;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(exp);
                tick(1);
                in_valid = 1'b0;
                return;
            end
            tick(1);
        end
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: got no in_ready expected fire");
        in_valid = 1'b0;
    endtask

    localparam logic [31:0] ACC_SEL2 = 32'h003F_8888;
    localparam logic [31:0] NEW_SEL2 = 32'h003F_9988;

    initial begin
        tick(3);
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_res_valid", {63'd0, res_valid}, 64'd0);
        check("rst_res_data", {res_read, res_write}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("init_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        check("run_in_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_write", {32'd0, a_o_write}, {32'd0, S});
            check("idle_res_valid", {63'd0, res_valid}, 64'd0);
        end
        @(posedge clk);
        #1;

        cfg_write(4'd11, 32'hFFFF_E000, 1'b0);
        cfg_write(4'd12, ACC_SEL2, 1'b1);

        send(32'd5, 32'd0, {S, S + 32'd5});
        check("latency_valid", {63'd0, res_valid}, 64'd1);
        tick(3);
        send(32'd7, 32'd0, {S + 32'd5, S + 32'd12});
        tick(3);
        send(32'd9, 32'd0, {S + 32'd12, S + 32'd21});
        tick(3);

        res_ready = 1'b0;
        send(32'd1, 32'd0, {S + 32'd21, S + 32'd22});
        send(32'd2, 32'd0, {S + 32'd22, S + 32'd24});
        in_pkt_1 = 32'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("full_in_ready", {63'd0, in_ready}, 64'd0);
            check("full_res_valid", {63'd0, res_valid}, 64'd1);
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        send(32'd3, 32'd0, {S + 32'd24, S + 32'd27});
        tick(4);

        cfg_write(4'd0, 32'd100, 1'b0);
        send(32'd1, 32'd50, {S + 32'd27, S + 32'd28});
        cfg_we = 1'b1;
        cfg_addr = 4'd12;
        cfg_data = NEW_SEL2;
        cfg_commit = 1'b1;
        send(32'd1, 32'd50, {S + 32'd28, S + 32'd29});
        cfg_we = 1'b0;
        cfg_commit = 1'b0;
        send(32'd1, 32'd50, {S + 32'd29, S + 32'd79});
        tick(3);

        res_ready = 1'b0;
        send(32'd1, 32'd50, {S + 32'd79, S + 32'd129});
        send(32'd1, 32'd50, {S + 32'd129, S + 32'd179});
        check("queued_valid", {63'd0, res_valid}, 64'd1);
        rst_n = 1'b0;
        exp_q.delete();
        tick(1);
        check("midrst_valid", {63'd0, res_valid}, 64'd0);
        check("midrst_data", {res_read, res_write}, 64'd0);
        rst_n = 1'b1;
        res_ready = 1'b1;
        cfg_write(4'd12, ACC_SEL2, 1'b1);
        send(32'd3, 32'd0, {S, S + 32'd3});
        tick(4);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nested_ifs_driver.md
Name: nested_ifs_driver

Overview:
Initiator-side companion for the nested-ifs stateful atom (module counter). Accepts packets on a valid/ready stream and drives the atom's pkt, cons, sel and rel_op inputs. Captures o__read/o__write into a result FIFO. The atom's state register updates on every clock, so on non-packet cycles the driver forces a hold configuration that makes the atom's next state equal its current state. The driver also holds the atom's configuration holes in a shadow/active register bank.

Parameters:
RES_DEPTH, 2, result FIFO depth; power of two, >= 2
CFG_WORDS, 13, localparam; number of configuration words (fixed)

Ports:
clk  in  1  clock; rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  packet valid
in_ready  out  1  packet accepted when in_valid & in_ready (a "fire")
in_pkt_1, in_pkt_2  in  32 each  packet fields
cfg_we  in  1  shadow-config word write
cfg_addr  in  4  config word address
cfg_data  in  32  config word data
cfg_commit  in  1  copy shadow bank to active bank
res_valid  out  1  result available
res_ready  in  1  result consumed when res_valid & res_ready
res_read, res_write  out  32 each  atom o__read / o__write captured at fire
a_pkt_1, a_pkt_2  out  32 each  to atom
a_cons_1..a_cons_11  out  32 each  to atom
a_sel_{1..7,10,13..16,19}  out  1 each  to atom
a_sel_{8,9,11,12,17,18,20,21}  out  2 each  to atom
a_rel_op1..3  out  2 each  to atom
a_o_read, a_o_write  in  32 each  from atom

Behaviour:
- Config map:
  - addr 0..10: cons_1..cons_11.
  - addr 11: bits [12:0] = sel_1..sel_7, sel_10, sel_13, sel_14, sel_15, sel_16, sel_19, in that order from bit 0; bits [31:13] are ignored.
  - addr 12: bits [15:0] = 2-bit sel_8, 9, 11, 12, 17, 18, 20, 21 from bit 0; bits [21:16] = rel_op1..rel_op3; remaining bits ignored.
  - addr 13..15: writes are dropped.
- cfg_we writes the shadow bank at the clock edge.
- cfg_commit copies shadow to active at the edge. If cfg_we and cfg_commit are asserted in the same cycle, the same-cycle write is included in the copy.
- A fire in the same cycle as a commit uses the old active bank.
- FSM states: INIT, RUN.
  - Reset forces INIT. The FSM spends exactly one cycle in INIT, then moves to RUN.
  - INIT drives the zero configuration: all four leaf state-muxes (sel_7, 10, 16, 19) = 1; leaf mux3 selects = 2 (cons); cons_3, 5, 8, 10 = seed; cons_4, 6, 9, 11 = 0. Atom state = seed after INIT, whatever branch is taken.
  - RUN, fire cycle: drive the active bank and a_pkt = in_pkt. Push {a_o_read, a_o_write} into the FIFO at the edge.
  - RUN, no fire: drive the hold configuration. All sel = 0 and a_pkt_1 = a_pkt_2 = 0, so o__write = state + pkt_1 - pkt_1 = state. cons and rel_op = 0.
- in_ready = (state == RUN) && FIFO count < RES_DEPTH. in_ready does not depend on res_ready.
- Result latency: res_valid rises the cycle after the fire.
- The FIFO preserves order. Simultaneous push and pop at full count is not possible because in_ready is low at full. Simultaneous push and pop at other counts leaves the count unchanged.
- Arithmetic is entirely inside the atom. The driver only registers values; all 32-bit values wrap modulo 2^32 inside the atom.
- Reset values: in_ready = 0, res_valid = 0, res_read = res_write = 0, FIFO empty, shadow and active banks = 0.
- Reset asserted mid-stream: FIFO contents are discarded and the one-cycle INIT re-seeds the atom state.

Optional Feature:
STATE_SEED_EN:
- Defined: adds input seed_value (32 bit); INIT loads the atom state with seed_value sampled in the INIT cycle.
- Undefined: seed is the constant 0 and the port is absent.

Decomposition:
- Package nested_ifs_pkg: int32_t, int2_t, bool typedefs; CFG_WORDS; address constants for cons words and the two select words; packed struct for the select words.
- One sub-module: nested_ifs_res_fifo (parameterised sync FIFO, RES_DEPTH entries, 64-bit payload).

Test Plan:
- Reset then idle 10 cycles: atom state stays 0 and o__write = 0 every cycle; in_ready goes high 2 cycles after rst_n rises.
- Config = accumulator (rel_op all 3 with cons = 0; state + pkt_1 - cons=0 on every leaf). Packets pkt_1 = 5, 7, 9 with 3 idle cycles between each: res_write = 5, 12, 21; res_read = 0, 5, 12.
- res_ready held 0 while firing: in_ready drops after RES_DEPTH = 2 fires; 3rd packet is not accepted until a pop, then results drain in order.
- Write cons_1 = 100 to shadow with no commit: next packet behaves with the old value. Commit with a same-cycle write of addr 12: next packet uses both new words.
- rst_n pulled low during 2 queued results: res_valid = 0 next cycle; after reset a packet with pkt_1 = 3 under accumulator config gives res_read = 0.
- STATE_SEED_EN, seed_value = 0x10: first accumulator packet with pkt_1 = 1 gives res_read = 0x10, res_write = 0x11.
